mem_access_responder: RTL and testbench
=======================================

MEM_ACCESS_RESPONDER -- requirements
Module: mem_access_responder

Interface
REQ-001 Parameter MEM_WORDS, default 4096: number of 32-bit words in the backing SRAM; local ADDR_W = clog2(MEM_WORDS).
REQ-002 Parameter READ_LATENCY, default 1: SRAM cycles from mem_en to valid mem_rdata; legal range 1-4.
REQ-003 clk  input  1  sole clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  core presents a fetch/load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = fetch/load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-010 req_unsigned  input  1  zero-extend load data when 1, sign-extend when 0.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 resp_valid  output  1  one-cycle pulse completing the accepted request.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_error  output  1  qualifies resp_valid; misaligned, out-of-range or illegal-size request.
REQ-015 mem_en  output  1  SRAM access strobe.
REQ-016 mem_we  output  4  SRAM byte-lane write enables; 0 on reads.
REQ-017 mem_addr  output  ADDR_W  SRAM word address = req_addr[ADDR_W+1:2].
REQ-018 mem_wdata  output  32  lane-replicated store data.
REQ-019 mem_rdata  input  32  SRAM read data, valid READ_LATENCY cycles after mem_en.

Function
REQ-020 States SHALL be IDLE, ISSUE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-021 Handshake: request accepted on a cycle with req_valid && req_ready; all request fields captured into registers that cycle; req_valid without req_ready is ignored and must be held by the core.
REQ-022 Error check at accept: size 3, half with addr[0]=1, word with addr[1:0]!=0, or req_addr[31:2] >= MEM_WORDS; erroring request goes IDLE->RESP directly, no SRAM access.
REQ-023 Legal request: IDLE->ISSUE; in ISSUE mem_en=1 for exactly one cycle with registered mem_addr/mem_we/mem_wdata.
REQ-024 Store lanes: byte mem_we = 1<<addr[1:0], wdata = 4 copies of byte; half mem_we = addr[1] ? 4'b1100 : 4'b0011, wdata = 2 copies of half; word mem_we = 4'b1111.
REQ-025 Store: ISSUE->RESP; latency accept->resp_valid = 2 cycles.
REQ-026 Load: ISSUE->WAIT; WAIT down-counter loaded with READ_LATENCY-1 exits when 0, capturing mem_rdata that cycle; latency accept->resp_valid = READ_LATENCY+2 cycles.
REQ-027 Load extraction: lane chosen by captured addr[1:0] (byte) or addr[1] (half); sign- or zero-extended per req_unsigned; word passed through.
REQ-028 RESP: resp_valid=1 for exactly one cycle, then IDLE; next request accepted no earlier than the cycle after RESP.
REQ-029 resp_rdata and resp_error SHALL be 0 whenever resp_valid=0; mem_en, mem_we = 0 outside ISSUE.

Reset
REQ-030 reset SHALL force IDLE; req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0 on the following cycle.
REQ-031 Reset mid-operation SHALL abandon the in-flight request with no resp_valid; late mem_rdata is ignored.
REQ-032 reset takes priority over a simultaneous req_valid.

Structure
REQ-033 Shared package SHALL hold size encodings (SIZE_BYTE/HALF/WORD), state encoding and the 32-bit data width constant.
REQ-034 Load lane select and extension SHALL live in sub-module mem_load_extend (combinational: rdata, addr[1:0], size, unsigned -> 32-bit result).

Verification
REQ-035 READ_LATENCY=1: word store 0xDEADBEEF to 0x10 accepted cycle N -> mem_we=4'b1111, mem_addr=4 at N+1; resp_valid, error=0 at N+2.
REQ-036 Byte load addr 0x13, mem_rdata 0x80FF_0000, unsigned=0 -> resp_rdata 0xFFFFFF80 at N+3; unsigned=1 -> 0x00000080.
REQ-037 Half store 0xABCD to 0x22 -> mem_we=4'b1100, mem_wdata=0xABCDABCD; half load at 0x21 -> resp_error=1 at N+1, mem_en never asserted.
REQ-038 READ_LATENCY=4: word load accepted N -> mem_en N+1, resp_valid N+6; req_ready low N+1..N+6, high N+7.
REQ-039 Addr 0x4000 with MEM_WORDS=4096 -> error response at N+1; reset asserted in WAIT -> no resp_valid, req_ready=1 the cycle after reset.

Source files
------------

// File: rtl/mem_access_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_responder_pkg
// Description : Shared encodings for the memory access responder: data width,
//               request size codes, FSM state encoding and store lane helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_responder_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_WORD    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Byte-lane write enables for a store of the given size at byte offset off.
  function automatic logic [3:0] store_we(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] we;
    we = 4'b0000;
    case (size)
      SIZE_BYTE: we = 4'b0001 << off;
      SIZE_HALF: we = off[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: we = 4'b1111;
      default:   we = 4'b0000;
    endcase
    return we;
  endfunction

  // Replicate right-aligned store data across all lanes it may land in.
  function automatic logic [DATA_W-1:0] store_data(input logic [1:0] size,
                                                   input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] d;
    d = wdata;
    case (size)
      SIZE_BYTE: d = {4{wdata[7:0]}};
      SIZE_HALF: d = {2{wdata[15:0]}};
      default:   d = wdata;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_extend
// Description : Selects the addressed byte/half lane of an SRAM read word and
//               sign- or zero-extends it to 32 bits; words pass through.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_extend
  import mem_access_responder_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by extension according to size and signedness.
  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    result   = '0;
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_BYTE: result = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
      SIZE_HALF: result = {{16{~load_unsigned & half_sel[15]}}, half_sel};
      SIZE_WORD: result = rdata;
      default:   result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_responder
// Description : Single-outstanding core-side memory responder. Accepts a
//               fetch/load/store, checks alignment/range/size, performs one
//               SRAM access and returns a one-cycle response pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_responder
  import mem_access_responder_pkg::*;
#(
  parameter  int MEM_WORDS    = 4096,
  parameter  int READ_LATENCY = 1,
  localparam int ADDR_W       = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);
  localparam logic [1:0]  CNT_LOAD    = 2'(READ_LATENCY - 1);

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              req_err;
  logic              write_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [1:0]        offset_q;
  logic              err_q;
  logic [3:0]        we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [1:0]        cnt_q;
  logic [31:0]       load_result;

  assign accept = req_valid && req_ready;

  // Request legality: illegal size, misalignment, or word index beyond the SRAM.
  always_comb begin
    req_err = 1'b0;
    if (req_size == SIZE_ILLEGAL)                         req_err = 1'b1;
    if (req_size == SIZE_HALF && req_addr[0])             req_err = 1'b1;
    if (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)  req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS_U)           req_err = 1'b1;
  end

  mem_load_extend u_load_extend (
    .rdata         (mem_rdata),
    .addr          (offset_q),
    .size          (size_q),
    .load_unsigned (unsigned_q),
    .result        (load_result)
  );

  // State register; reset wins over any concurrent request.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state: errors skip the SRAM, stores skip the read wait.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = req_err ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_next = write_q ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (cnt_q == 2'd0) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; response fields are forced to zero outside RESP.
  always_comb begin
    req_ready  = (state == ST_IDLE);
    mem_en     = (state == ST_ISSUE);
    mem_we     = (state == ST_ISSUE) ? we_q : 4'b0000;
    resp_valid = (state == ST_RESP);
    resp_error = (state == ST_RESP) && err_q;
    resp_rdata = (state == ST_RESP) ? rdata_q : 32'h0;
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Request capture, read-latency countdown and load data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q    <= 1'b0;
      size_q     <= SIZE_BYTE;
      unsigned_q <= 1'b0;
      offset_q   <= 2'b00;
      err_q      <= 1'b0;
      we_q       <= 4'b0000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      cnt_q      <= 2'd0;
    end else begin
      if (accept) begin
        write_q    <= req_write;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        offset_q   <= req_addr[1:0];
        err_q      <= req_err;
        we_q       <= (req_write && !req_err) ? store_we(req_size, req_addr[1:0]) : 4'b0000;
        addr_q     <= req_addr[ADDR_W+1:2];
        wdata_q    <= store_data(req_size, req_wdata);
        rdata_q    <= 32'h0;
      end
      if (state == ST_ISSUE) begin
        cnt_q <= CNT_LOAD;
      end else if (state == ST_WAIT && cnt_q != 2'd0) begin
        cnt_q <= cnt_q - 2'd1;
      end
      if (state == ST_WAIT && cnt_q == 2'd0) begin
        rdata_q <= load_result;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_responder
// Description : Directed self-checking bench; one instance at READ_LATENCY=1
//               and one at READ_LATENCY=4. Inputs and samples on negedge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // READ_LATENCY = 1 instance
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata, resp_rdata, mem_wdata, mem_rdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_error, mem_en;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;

  // READ_LATENCY = 4 instance
  logic        l4_req_valid, l4_req_ready, l4_req_write, l4_req_unsigned;
  logic [31:0] l4_req_addr, l4_req_wdata, l4_resp_rdata, l4_mem_wdata, l4_mem_rdata;
  logic [1:0]  l4_req_size;
  logic        l4_resp_valid, l4_resp_error, l4_mem_en;
  logic [3:0]  l4_mem_we;
  logic [11:0] l4_mem_addr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_responder #(.MEM_WORDS(4096), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_access_responder #(.MEM_WORDS(4096), .READ_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset),
    .req_valid(l4_req_valid), .req_ready(l4_req_ready), .req_write(l4_req_write),
    .req_addr(l4_req_addr), .req_size(l4_req_size), .req_unsigned(l4_req_unsigned),
    .req_wdata(l4_req_wdata), .resp_valid(l4_resp_valid), .resp_rdata(l4_resp_rdata),
    .resp_error(l4_resp_error), .mem_en(l4_mem_en), .mem_we(l4_mem_we),
    .mem_addr(l4_mem_addr), .mem_wdata(l4_mem_wdata), .mem_rdata(l4_mem_rdata)
  );

  task automatic drive_req(input logic w, input logic [31:0] a, input logic [1:0] s,
                           input logic u, input logic [31:0] d);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = s;
    req_unsigned = u; req_wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_req(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
    l4_req_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", req_ready); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
      n_checks++; if (resp_error !== 1'b0) begin n_fail++; $display("FAIL rst_resp_error: got %b want 0", resp_error); end
      n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
      n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
      n_checks++; if (mem_we !== 4'h0) begin n_fail++; $display("FAIL rst_mem_we: got %h want 0", mem_we); end
      n_checks++; if (mem_addr !== 12'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
      n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
      n_checks++; if (l4_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_l4_ready: got %b want 1", l4_req_ready); end
    end
    req_valid = 1'b0; l4_req_valid = 1'b0; reset = 1'b0;
    @(negedge clk);
  endtask

  // Legal store on the latency-1 instance; accept at cycle N, checks N..N+3.
  task automatic test_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d,
                            input logic [3:0] exp_we, input logic [31:0] exp_wd,
                            input logic [11:0] exp_ma, input string nm);
    drive_req(1'b1, a, s, 1'b0, d);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready_N: got %b want 1", nm, req_ready); end
    @(negedge clk); req_valid = 1'b0;
    n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL %s_mem_en: got %b want 1", nm, mem_en); end
    n_checks++; if (mem_we !== exp_we) begin n_fail++; $display("FAIL %s_mem_we: got %h want %h", nm, mem_we, exp_we); end
    n_checks++; if (mem_addr !== exp_ma) begin n_fail++; $display("FAIL %s_mem_addr: got %h want %h", nm, mem_addr, exp_ma); end
    n_checks++; if (mem_wdata !== exp_wd) begin n_fail++; $display("FAIL %s_mem_wdata: got %h want %h", nm, mem_wdata, exp_wd); end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL %s_ready_N1: got %b want 0", nm, req_ready); end
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL %s_resp_valid: got %b want 1", nm, resp_valid); end
    n_checks++; if (resp_error !== 1'b0) begin n_fail++; $display("FAIL %s_resp_error: got %b want 0", nm, resp_error); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL %s_resp_rdata: got %h want 0", nm, resp_rdata); end
    n_checks++; if (mem_en !== 1'b0 || mem_we !== 4'h0) begin n_fail++; $display("FAIL %s_mem_idle: got en=%b we=%h want 0/0", nm, mem_en, mem_we); end
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL %s_after: got valid=%b ready=%b want 0/1", nm, resp_valid, req_ready); end
  endtask

  // Legal load on the latency-1 instance; SRAM data is only valid at N+2.
  task automatic test_load(input logic [31:0] a, input logic [1:0] s, input logic u,
                           input logic [31:0] rd, input logic [31:0] exp, input string nm);
    drive_req(1'b0, a, s, u, 32'h0);
    @(negedge clk); req_valid = 1'b0;
    n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL %s_mem_en: got %b want 1", nm, mem_en); end
    n_checks++; if (mem_we !== 4'h0) begin n_fail++; $display("FAIL %s_mem_we: got %h want 0", nm, mem_we); end
    n_checks++; if (mem_addr !== a[13:2]) begin n_fail++; $display("FAIL %s_mem_addr: got %h want %h", nm, mem_addr, a[13:2]); end
    @(negedge clk); mem_rdata = rd;
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early_valid: got %b want 0", nm, resp_valid); end
    @(negedge clk); mem_rdata = 32'h5A5A_A5A5;
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL %s_resp_valid: got %b want 1", nm, resp_valid); end
    n_checks++; if (resp_error !== 1'b0) begin n_fail++; $display("FAIL %s_resp_error: got %b want 0", nm, resp_error); end
    n_checks++; if (resp_rdata !== exp) begin n_fail++; $display("FAIL %s_resp_rdata: got %h want %h", nm, resp_rdata, exp); end
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin n_fail++; $display("FAIL %s_after: got valid=%b rdata=%h want 0/0", nm, resp_valid, resp_rdata); end
  endtask

  // Erroring request: response at N+1, SRAM never strobed.
  task automatic test_error(input logic w, input logic [31:0] a, input logic [1:0] s, input string nm);
    drive_req(w, a, s, 1'b0, 32'h1234_5678);
    n_checks++; if (req_ready !== 1'b1 || mem_en !== 1'b0) begin n_fail++; $display("FAIL %s_N: got ready=%b en=%b want 1/0", nm, req_ready, mem_en); end
    @(negedge clk); req_valid = 1'b0;
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL %s_resp_valid: got %b want 1", nm, resp_valid); end
    n_checks++; if (resp_error !== 1'b1) begin n_fail++; $display("FAIL %s_resp_error: got %b want 1", nm, resp_error); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL %s_resp_rdata: got %h want 0", nm, resp_rdata); end
    n_checks++; if (mem_en !== 1'b0 || mem_we !== 4'h0) begin n_fail++; $display("FAIL %s_mem: got en=%b we=%h want 0/0", nm, mem_en, mem_we); end
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1 || resp_error !== 1'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL %s_after: got ready=%b err=%b en=%b want 1/0/0", nm, req_ready, resp_error, mem_en); end
  endtask

  // req_valid held while busy is ignored; same request is re-accepted after RESP.
  task automatic test_back_to_back();
    logic [5:0] exp_en  = 6'b001001;  // bit k-1 = cycle N+k
    logic [5:0] exp_rv  = 6'b010010;
    logic [5:0] exp_rdy = 6'b100100;
    drive_req(1'b1, 32'h20, 2'd2, 1'b0, 32'h0BB0_0BB0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) req_valid = 1'b0;
      n_checks++; if (mem_en !== exp_en[k-1]) begin n_fail++; $display("FAIL b2b_en_%0d: got %b want %b", k, mem_en, exp_en[k-1]); end
      n_checks++; if (resp_valid !== exp_rv[k-1]) begin n_fail++; $display("FAIL b2b_rv_%0d: got %b want %b", k, resp_valid, exp_rv[k-1]); end
      n_checks++; if (req_ready !== exp_rdy[k-1]) begin n_fail++; $display("FAIL b2b_rdy_%0d: got %b want %b", k, req_ready, exp_rdy[k-1]); end
    end
  endtask

  // READ_LATENCY=4: data valid only at N+5, response at N+6, ready back at N+7.
  task automatic test_latency4();
    l4_req_valid = 1'b1; l4_req_write = 1'b0; l4_req_addr = 32'h8;
    l4_req_size = 2'd2; l4_req_unsigned = 1'b0; l4_req_wdata = 32'h0;
    n_checks++; if (l4_req_ready !== 1'b1) begin n_fail++; $display("FAIL l4_ready_N: got %b want 1", l4_req_ready); end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      l4_req_valid = 1'b0;
      l4_mem_rdata = (k == 5) ? 32'hCAFE_F00D : 32'h0BAD_0BAD;
      n_checks++; if (l4_mem_en !== (k == 1)) begin n_fail++; $display("FAIL l4_en_%0d: got %b want %b", k, l4_mem_en, (k == 1)); end
      n_checks++; if (l4_resp_valid !== (k == 6)) begin n_fail++; $display("FAIL l4_rv_%0d: got %b want %b", k, l4_resp_valid, (k == 6)); end
      n_checks++; if (l4_req_ready !== (k == 7)) begin n_fail++; $display("FAIL l4_rdy_%0d: got %b want %b", k, l4_req_ready, (k == 7)); end
      if (k == 1) begin
        n_checks++; if (l4_mem_addr !== 12'h2) begin n_fail++; $display("FAIL l4_mem_addr: got %h want 002", l4_mem_addr); end
      end
      if (k == 6) begin
        n_checks++; if (l4_resp_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL l4_rdata: got %h want cafef00d", l4_resp_rdata); end
      end
    end
    l4_mem_rdata = 32'h0;
  endtask

  // Reset during WAIT abandons the load; late SRAM data produces nothing.
  task automatic test_reset_in_wait();
    l4_req_valid = 1'b1; l4_req_write = 1'b0; l4_req_addr = 32'h40;
    l4_req_size = 2'd2; l4_req_unsigned = 1'b0;
    @(negedge clk); l4_req_valid = 1'b0;          // N+1 ISSUE
    @(negedge clk);                                 // N+2 WAIT
    @(negedge clk); reset = 1'b1;                   // N+3 WAIT, reset sampled at next edge
    @(negedge clk); reset = 1'b0;                   // N+4 after reset
    n_checks++; if (l4_req_ready !== 1'b1) begin n_fail++; $display("FAIL rw_ready: got %b want 1", l4_req_ready); end
    n_checks++; if (l4_mem_addr !== 12'h0) begin n_fail++; $display("FAIL rw_mem_addr: got %h want 0", l4_mem_addr); end
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (l4_resp_valid !== 1'b0 || l4_mem_en !== 1'b0) begin n_fail++; $display("FAIL rw_quiet_%0d: got valid=%b en=%b want 0/0", k, l4_resp_valid, l4_mem_en); end
      l4_mem_rdata = 32'h7777_0000 + 32'(k);
      @(negedge clk);
    end
    l4_mem_rdata = 32'h0;
  endtask

  initial begin
    reset = 1'b1; mem_rdata = 32'h0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'h0;
    l4_req_valid = 1'b0; l4_req_write = 1'b0; l4_req_addr = 32'h0; l4_req_size = 2'd0;
    l4_req_unsigned = 1'b0; l4_req_wdata = 32'h0; l4_mem_rdata = 32'h0;

    test_reset();
    test_store(32'h10, 2'd2, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 12'h004, "st_word");
    test_store(32'h22, 2'd1, 32'h0000ABCD, 4'b1100, 32'hABCDABCD, 12'h008, "st_half");
    test_store(32'h11, 2'd0, 32'h0000005A, 4'b0010, 32'h5A5A5A5A, 12'h004, "st_byte");
    test_load(32'h13, 2'd0, 1'b0, 32'h80FF_0000, 32'hFFFF_FF80, "ld_byte_s");
    test_load(32'h13, 2'd0, 1'b1, 32'h80FF_0000, 32'h0000_0080, "ld_byte_u");
    test_load(32'h22, 2'd1, 1'b0, 32'h8001_7FFF, 32'hFFFF_8001, "ld_half_s");
    test_load(32'h20, 2'd1, 1'b1, 32'h8001_9FFF, 32'h0000_9FFF, "ld_half_u");
    test_load(32'h3FFC, 2'd2, 1'b0, 32'h1357_9BDF, 32'h1357_9BDF, "ld_word_top");
    test_error(1'b0, 32'h21, 2'd1, "err_half_mis");
    test_error(1'b0, 32'h4000, 2'd2, "err_range");
    test_error(1'b1, 32'h16, 2'd2, "err_word_mis");
    test_error(1'b0, 32'h0, 2'd3, "err_size");
    test_back_to_back();
    test_latency4();
    test_reset_in_wait();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
